// File: rtl/amdc_spi_master_multi_if.sv
// Purpose: bundles the trigger, serial and result signals of the multi-channel ADC SPI master.
// Latency: none, wiring only.
// Backpressure: none; start is a sampled trigger, results are levels and pulses.
interface amdc_spi_master_multi_if #(
  parameter int NUM_CH    = 2,
  parameter int DATA_BITS = 18
);
  logic                          start;
  logic                          clr_overrun;
  logic [NUM_CH-1:0]             miso;
  logic                          sclk;
  logic                          cnv;
  logic [NUM_CH*DATA_BITS-1:0]   sensor_data;
  logic                          data_valid;
  logic                          done;
  logic                          busy;
  logic                          overrun;
  logic [15:0]                   overrun_cnt;

  // The SPI master side: takes the trigger and serial data, drives the ADC strobes and results.
  modport master (
    input  start, clr_overrun, miso,
    output sclk, cnv, sensor_data, data_valid, done, busy, overrun, overrun_cnt
  );

  // The trigger/register-file side plus the ADCs.
  modport slave (
    output start, clr_overrun, miso,
    input  sclk, cnv, sensor_data, data_valid, done, busy, overrun, overrun_cnt
  );
endinterface

// File: rtl/amdc_spi_master_multi.sv
// Purpose: one shared CNV/SCLK pair to NUM_CH ADCs, captures NUM_CH MSB-first words per trigger.
// Latency: CNV_CYCLES + 2*DATA_BITS*SCLK_HALF_DIV clk from start to done, then QUIET_CYCLES idle.
// Backpressure: none; starts arriving while busy are dropped and flagged as overrun.
// Optional: define AMDC_SPI_OVERRUN_CNT_EN to build the saturating ignored-trigger counter.
module amdc_spi_master_multi #(
  parameter int NUM_CH        = 2,
  parameter int DATA_BITS     = 18,
  parameter int SCLK_HALF_DIV = 10,
  parameter int CNV_CYCLES    = 64,
  parameter int QUIET_CYCLES  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  amdc_spi_master_multi_if.master        bus
);

  // Counter widths cover the largest legal parameter values.
  localparam int CNT_W  = $clog2(1024);
  localparam int HALF_W = $clog2(256);
  localparam int BIT_W  = $clog2(33);

  typedef enum logic [1:0] {S_IDLE, S_CNV, S_RX, S_QUIET} state_t;

  state_t                        state, state_nxt;
  logic [CNT_W-1:0]              cnt;
  logic [HALF_W-1:0]             half_cnt;
  logic [BIT_W-1:0]              bit_cnt;
  logic [NUM_CH-1:0]             miso_meta, miso_sync;
  logic [DATA_BITS-1:0]          shreg [NUM_CH];
  logic [NUM_CH*DATA_BITS-1:0]   data_q;
  logic                          sclk_q, cnv_q, done_q, dv_q, ovr_q;
  logic                          half_end, fall_evt, last_fall, cnv_end, quiet_end;
  logic                          accept, ignored;

  // Next-state logic and the per-cycle events that drive the datapath.
  always_comb begin
    state_nxt = state;
    half_end  = (half_cnt == HALF_W'(SCLK_HALF_DIV - 1));
    fall_evt  = (state == S_RX) && half_end && sclk_q;
    last_fall = fall_evt && (bit_cnt == BIT_W'(DATA_BITS - 1));
    cnv_end   = (state == S_CNV) && (cnt == CNT_W'(CNV_CYCLES - 1));
    quiet_end = (state == S_QUIET) && (cnt == CNT_W'(QUIET_CYCLES - 1));
    accept    = (state == S_IDLE) && bus.start;
    // A start on the edge that re-enters IDLE is still seen in a busy state, so it is dropped.
    ignored   = (state != S_IDLE) && bus.start;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_CNV;
      S_CNV:   if (cnv_end)   state_nxt = S_RX;
      S_RX:    if (last_fall) state_nxt = (QUIET_CYCLES == 0) ? S_IDLE : S_QUIET;
      S_QUIET: if (quiet_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // CNV / QUIET duration counter, restarted on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    cnt <= '0;
    else if (state_nxt != state)                   cnt <= '0;
    else if (state == S_CNV || state == S_QUIET)   cnt <= cnt + CNT_W'(1);
  end

  // SCLK generator: starts low in RX, toggles every SCLK_HALF_DIV clocks, counts falling edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      sclk_q   <= 1'b0;
    end else if (state != S_RX) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      sclk_q   <= 1'b0;
    end else if (half_end) begin
      half_cnt <= '0;
      sclk_q   <= ~sclk_q;
      if (fall_evt) bit_cnt <= bit_cnt + BIT_W'(1);
    end else begin
      half_cnt <= half_cnt + HALF_W'(1);
    end
  end

  // CNV strobe registered from the next state so it is high exactly while in CNV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnv_q <= 1'b0;
    else        cnv_q <= (state_nxt == S_CNV);
  end

  // Two-flop synchroniser for the asynchronous MISO lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta <= '0;
      miso_sync <= '0;
    end else begin
      miso_meta <= bus.miso;
      miso_sync <= miso_meta;
    end
  end

  // Per-channel shift registers, one bit in at the LSB per SCLK falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) shreg[k] <= '0;
    end else if (fall_evt) begin
      for (int k = 0; k < NUM_CH; k++) shreg[k] <= {shreg[k][DATA_BITS-2:0], miso_sync[k]};
    end
  end

  // Result register: whole frame loaded together with the final bit, so no partial words leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      done_q <= 1'b0;
      dv_q   <= 1'b0;
    end else begin
      done_q <= last_fall;
      if (last_fall) begin
        for (int k = 0; k < NUM_CH; k++)
          data_q[k*DATA_BITS +: DATA_BITS] <= {shreg[k][DATA_BITS-2:0], miso_sync[k]};
        dv_q <= 1'b1;
      end else if (accept) begin
        dv_q <= 1'b0;
      end
    end
  end

  // Sticky overrun flag; a new ignored start beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               ovr_q <= 1'b0;
    else if (ignored)         ovr_q <= 1'b1;
    else if (bus.clr_overrun) ovr_q <= 1'b0;
  end

`ifdef AMDC_SPI_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt;

  // Saturating count of ignored starts; an increment together with a clear yields 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt <= '0;
    end else if (ignored) begin
      if (bus.clr_overrun)          ovr_cnt <= 16'd1;
      else if (ovr_cnt != 16'hFFFF) ovr_cnt <= ovr_cnt + 16'd1;
    end else if (bus.clr_overrun) begin
      ovr_cnt <= '0;
    end
  end

  assign bus.overrun_cnt = ovr_cnt;
`else
  assign bus.overrun_cnt = 16'h0000;
`endif

  assign bus.sclk        = sclk_q;
  assign bus.cnv         = cnv_q;
  assign bus.sensor_data = data_q;
  assign bus.data_valid  = dv_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_amdc_spi_master_multi.sv
// Bench for amdc_spi_master_multi: default build plus a minimal-parameter instance.
// ADC models shift their words out MSB-first; expected results come from the stored patterns.
// Overrun counter expectations follow AMDC_SPI_OVERRUN_CNT_EN.
module tb_amdc_spi_master_multi;

  localparam int NCH = 2;
  localparam int DB  = 18;
`ifdef AMDC_SPI_OVERRUN_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  amdc_spi_master_multi_if #(.NUM_CH(NCH), .DATA_BITS(DB)) ifa ();
  amdc_spi_master_multi_if #(.NUM_CH(1),   .DATA_BITS(2))  ifb ();

  amdc_spi_master_multi #(
    .NUM_CH(NCH), .DATA_BITS(DB), .SCLK_HALF_DIV(10), .CNV_CYCLES(64), .QUIET_CYCLES(4)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  amdc_spi_master_multi #(
    .NUM_CH(1), .DATA_BITS(2), .SCLK_HALF_DIV(1), .CNV_CYCLES(1), .QUIET_CYCLES(0)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ADC A model: MSB presented once CNV is seen, next bit after each observed SCLK fall.
  logic [DB-1:0] pat_a [NCH];
  int   idx_a = DB;
  logic sclk_a_prev = 1'b0;
  always @(negedge clk) begin
    if (ifa.cnv) idx_a = 0;
    else if (sclk_a_prev && !ifa.sclk) idx_a = idx_a + 1;
    sclk_a_prev = ifa.sclk;
    for (int k = 0; k < NCH; k++) ifa.miso[k] = (idx_a < DB) ? pat_a[k][DB-1-idx_a] : 1'b0;
  end

  // ADC B model: with one-clock half periods the data leads by a rising edge to clear the synchroniser.
  logic [1:0] pat_b = 2'b00;
  int   idx_b = 2;
  logic sclk_b_prev = 1'b0;
  always @(negedge clk) begin
    if (ifb.cnv) idx_b = 0;
    else if (!sclk_b_prev && ifb.sclk) idx_b = idx_b + 1;
    sclk_b_prev = ifb.sclk;
    ifb.miso[0] = (idx_b < 2) ? pat_b[1-idx_b] : 1'b0;
  end

  // Bench-side expectations of the DUT A result and overrun state.
  logic [NCH*DB-1:0] prev_exp = '0;
  logic              exp_ovr  = 1'b0;
  int                exp_cnt  = 0;

  typedef struct {
    logic [DB-1:0]     p0;
    logic [DB-1:0]     p1;
    logic [NCH*DB-1:0] exp;
    bit                inject;
  } vec_t;

  // One full DUT A frame with timing checks; inject drops starts into CNV, RX and QUIET.
  task automatic run_frame_a(input logic [DB-1:0] p0, input logic [DB-1:0] p1,
                             input logic [NCH*DB-1:0] exp, input bit inject);
    int n_cnv, n_rx, n_q, guard;
    pat_a[0] = p0;
    pat_a[1] = p1;
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    chk("dv_clear_on_start", ifa.data_valid, 1'b0);
    chk("busy_in_cnv", ifa.busy, 1'b1);
    n_cnv = 0; guard = 0;
    while (ifa.cnv && guard < 2000) begin
      n_cnv++; guard++;
      ifa.start = inject && (n_cnv == 10);
      @(negedge clk);
    end
    chk("cnv_len", n_cnv, 64);
    n_rx = 0; guard = 0;
    while (!ifa.done && guard < 2000) begin
      n_rx++; guard++;
      if (n_rx == 1)   chk("sclk_starts_low", ifa.sclk, 1'b0);
      if (n_rx == 180) chk("data_hold_mid_rx", ifa.sensor_data, prev_exp);
      ifa.start = inject && (n_rx == 180);
      @(negedge clk);
    end
    ifa.start = 1'b0;
    chk("rx_len", n_rx, 360);
    chk("frame_data", ifa.sensor_data, exp);
    chk("dv_set", ifa.data_valid, 1'b1);
    prev_exp = exp;
    n_q = 0; guard = 0;
    while (ifa.busy && guard < 1000) begin
      n_q++; guard++;
      ifa.start = inject && (n_q == 2);
      @(negedge clk);
      if (n_q == 1) chk("done_width", ifa.done, 1'b0);
    end
    ifa.start = 1'b0;
    chk("quiet_len", n_q, 4);
    if (inject) begin
      exp_ovr = 1'b1;
      exp_cnt = exp_cnt + 3;
    end
    chk("overrun", ifa.overrun, exp_ovr);
    chk("overrun_cnt", ifa.overrun_cnt, CNT_EN ? exp_cnt : 0);
  endtask

  initial begin
    vec_t tbl [4];
    int   n, guard;
    logic [DB-1:0] r0, r1;

    ifa.start = 1'b0; ifa.clr_overrun = 1'b0;
    ifb.start = 1'b0; ifb.clr_overrun = 1'b0;
    for (int k = 0; k < NCH; k++) pat_a[k] = '0;

    tbl[0] = '{18'h2A5C3, 18'h3FFFF, 36'hFFFFEA5C3, 1'b0};
    tbl[1] = '{18'h00001, 18'h20000, 36'h800000001, 1'b0};
    tbl[2] = '{18'h15555, 18'h0AAAA, 36'h2AAA95555, 1'b1};
    tbl[3] = '{18'h00000, 18'h3FFFF, 36'hFFFFC0000, 1'b0};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_sclk", ifa.sclk, 1'b0);
    chk("rst_cnv", ifa.cnv, 1'b0);
    chk("rst_data", ifa.sensor_data, '0);
    chk("rst_dv", ifa.data_valid, 1'b0);
    chk("rst_done", ifa.done, 1'b0);
    chk("rst_busy", ifa.busy, 1'b0);
    chk("rst_ovr", ifa.overrun, 1'b0);
    chk("rst_ovr_cnt", ifa.overrun_cnt, 16'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table: basic frame, back-to-back update, overrun injection, edge patterns.
    for (int i = 0; i < 4; i++) run_frame_a(tbl[i].p0, tbl[i].p1, tbl[i].exp, tbl[i].inject);

    // Clearing overrun.
    @(negedge clk); ifa.clr_overrun = 1'b1;
    @(negedge clk); ifa.clr_overrun = 1'b0;
    chk("clr_ovr", ifa.overrun, 1'b0);
    chk("clr_ovr_cnt", ifa.overrun_cnt, 16'h0);
    exp_ovr = 1'b0; exp_cnt = 0;

    // Clear and ignored start in the same cycle: set wins.
    pat_a[0] = 18'h12345; pat_a[1] = 18'h0F0F0;
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    repeat (3) @(negedge clk);
    ifa.start = 1'b1; ifa.clr_overrun = 1'b1;
    @(negedge clk); ifa.start = 1'b0; ifa.clr_overrun = 1'b0;
    chk("clr_vs_set_ovr", ifa.overrun, 1'b1);
    chk("clr_vs_set_cnt", ifa.overrun_cnt, CNT_EN ? 16'd1 : 16'd0);
    guard = 0;
    while (ifa.busy && guard < 2000) begin guard++; @(negedge clk); end
    chk("clr_vs_set_data", ifa.sensor_data, {18'h0F0F0, 18'h12345});
    prev_exp = {18'h0F0F0, 18'h12345};

    // Asynchronous reset in the middle of RX with SCLK high.
    pat_a[0] = 18'h3C3C3; pat_a[1] = 18'h00F0F;
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0;
    guard = 0;
    while (!ifa.sclk && guard < 2000) begin guard++; @(negedge clk); end
    repeat (3 * 20) @(negedge clk);
    guard = 0;
    while (!ifa.sclk && guard < 100) begin guard++; @(negedge clk); end
    chk("pre_rst_sclk_high", ifa.sclk, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sclk", ifa.sclk, 1'b0);
    chk("arst_cnv", ifa.cnv, 1'b0);
    chk("arst_busy", ifa.busy, 1'b0);
    chk("arst_data", ifa.sensor_data, '0);
    chk("arst_dv", ifa.data_valid, 1'b0);
    chk("arst_ovr", ifa.overrun, 1'b0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    prev_exp = '0; exp_ovr = 1'b0; exp_cnt = 0;
    @(negedge clk);
    run_frame_a(18'h3C3C3, 18'h00F0F, {18'h00F0F, 18'h3C3C3}, 1'b0);

    // Randomized frames against the pattern model.
    for (int i = 0; i < 3; i++) begin
      r0 = DB'($urandom());
      r1 = DB'($urandom());
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_frame_a(r0, r1, {r1, r0}, 1'b0);
    end

    // Minimal configuration with a continuously held start.
    pat_b = 2'b10;
    @(negedge clk); ifb.start = 1'b1;
    @(negedge clk);
    n = 0; guard = 0;
    while (ifb.cnv && guard < 100) begin n++; guard++; @(negedge clk); end
    chk("b_cnv_len", n, 1);
    n = 0; guard = 0;
    while (!ifb.done && guard < 100) begin n++; guard++; @(negedge clk); end
    chk("b_rx_len", n, 4);
    chk("b_data", ifb.sensor_data, 2'b10);
    chk("b_dv", ifb.data_valid, 1'b1);
    chk("b_idle_at_done", ifb.busy, 1'b0);
    chk("b_ovr_held_start", ifb.overrun, 1'b1);
    @(negedge clk);
    chk("b_retrigger", ifb.cnv, 1'b1);
    chk("b_dv_clear", ifb.data_valid, 1'b0);
    ifb.start = 1'b0;
    guard = 0;
    while (!ifb.done && guard < 100) begin guard++; @(negedge clk); end
    chk("b_data2", ifb.sensor_data, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/amdc_spi_master_multi.md
Name: amdc_spi_master_multi

Overview:
Parametrised successor to the single-pair eddy-current ADC SPI driver.
- On each start trigger, drives one shared CNV/SCLK pair to NUM_CH AD4011-class ADCs.
- Captures DATA_BITS-bit MSB-first words from NUM_CH MISO lines into a flat, atomically updated output register.
- Adds an enforced post-frame quiet time, a busy indication, overrun detection and a one-cycle completion pulse.
- Sits between the PWM-synchronised trigger logic and the AXI register file.

Parameters:
NUM_CH, 2, number of MISO channels, legal 1..8
DATA_BITS, 18, bits per conversion word, legal 2..32
SCLK_HALF_DIV, 10, clk cycles per SCLK half-period, legal 1..255
CNV_CYCLES, 64, clk cycles CNV is held high, legal 1..1023
QUIET_CYCLES, 4, clk cycles of enforced idle after a frame before a new start is accepted, legal 0..255

Ports:
clk  input  1  system clock (AXI clock)
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion trigger, sampled each clk
clr_overrun  input  1  clears the overrun flag
miso  input  NUM_CH  serial data, channel k on bit k, asynchronous to clk
sclk  output  1  SPI clock, idles low
cnv  output  1  ADC convert strobe, registered
sensor_data  output  NUM_CH*DATA_BITS  channel k word at [k*DATA_BITS +: DATA_BITS]
data_valid  output  1  level, sensor_data holds a completed frame
done  output  1  one-cycle pulse at frame completion
busy  output  1  high in any state other than IDLE
overrun  output  1  sticky, set when start arrives while busy
overrun_cnt  output  16  count of ignored triggers (see optional feature)

Behaviour:
- Reset (async, any time including mid-frame): state IDLE; sclk=0, cnv=0, sensor_data=0, data_valid=0, done=0, busy=0, overrun=0, overrun_cnt=0; all counters and shift registers 0.
- States:
  - IDLE: start=1 -> CNV; on that edge data_valid clears.
  - CNV: cnv=1 for exactly CNV_CYCLES consecutive clk cycles, starting the cycle after start is sampled; then -> RX, with cnv=0 on the first RX cycle.
  - RX: sclk begins low; toggles every SCLK_HALF_DIV clk cycles; exactly DATA_BITS full periods, so RX lasts 2*DATA_BITS*SCLK_HALF_DIV cycles and ends with sclk low. After the DATA_BITS-th falling edge -> QUIET.
  - QUIET: lasts QUIET_CYCLES cycles, then -> IDLE. QUIET_CYCLES=0 means RX goes directly to IDLE.
- MISO capture:
  - Each miso bit is double-flopped into clk.
  - On each internal sclk falling-edge event, every channel shifts its synchronised bit in at the LSB; the first bit captured ends at the MSB.
  - Per-channel shift registers are internal; sensor_data never shows partial frames.
- Completion:
  - On the cycle RX ends, sensor_data is loaded from the shift registers, done pulses high for 1 cycle and data_valid sets.
  - All three take effect on the same clk edge.
- busy=1 in CNV, RX and QUIET.
- start while busy: ignored, no restart; overrun sets on the next edge.
- clr_overrun: clears overrun. If the same cycle also sets overrun, set wins.
- Simultaneous start with the IDLE entry edge (QUIET->IDLE): that start is ignored and flags overrun; only a start sampled while in IDLE is accepted.
- Counter widths: sized by $clog2 of the parameter maxima; bit counter saturates are not required because the FSM exits at DATA_BITS.

Optional Feature:
AMDC_SPI_OVERRUN_CNT_EN
- Defined: overrun_cnt increments by 1 on each ignored start and saturates at 16'hFFFF. clr_overrun clears it to 0; an increment in the same cycle wins and gives 1.
- Undefined: overrun_cnt is tied to 16'h0000 and no counter logic is instantiated; overrun behaves identically either way.

Test Plan:
1. Defaults, miso[0] drives 18'h2A5C3 and miso[1] drives 18'h3FFFF MSB-first on the ADC timing; 1-cycle start.
   - cnv high exactly 64 cycles; RX lasts 360 cycles.
   - done 1 cycle; sensor_data = {18'h3FFFF, 18'h2A5C3}; data_valid=1.
2. Second start after 1 with new patterns.
   - data_valid clears on the start edge.
   - sensor_data holds the old value until the new done, then updates atomically.
3. start pulses at cycle 10 of CNV, mid-RX and during QUIET.
   - Frame timing unchanged; overrun=1.
   - With the macro defined, overrun_cnt=3; clr_overrun -> 0.
4. Assert rst_n low mid-RX with sclk high.
   - Immediately sclk=0, cnv=0, busy=0, sensor_data=0.
   - A start after release runs a full clean frame.
5. NUM_CH=1, DATA_BITS=2, SCLK_HALF_DIV=1, CNV_CYCLES=1, QUIET_CYCLES=0, miso = 1,0.
   - cnv high 1 cycle; RX 4 cycles; sensor_data=2'b10.
   - A start held continuously re-triggers on the first IDLE cycle.
6. clr_overrun and an ignored start in the same cycle.
   - overrun stays 1; overrun_cnt increments by 1 (macro defined) or stays 0 (macro undefined).
